// File: rtl/data_mem_responder_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - MMIO register offsets within the 16-byte page
//   - STATUS register bit positions
//   - address-region decode enum and helper function
package dmem_pkg;

  // Byte offsets of the MMIO registers; only bits [3:2] select a register.
  localparam logic [3:0] OFS_TX_DATA = 4'h0;
  localparam logic [3:0] OFS_STATUS  = 4'h4;
  localparam logic [3:0] OFS_CYCLE   = 4'h8;
  localparam logic [3:0] OFS_TOHOST  = 4'hC;

  // STATUS layout: {23'b0, overflow, full, empty, count[5:0]}
  localparam int STATUS_COUNT_W      = 6;
  localparam int STATUS_EMPTY_BIT    = 6;
  localparam int STATUS_FULL_BIT     = 7;
  localparam int STATUS_OVERFLOW_BIT = 8;

  typedef enum logic [1:0] {
    REGION_RAM   = 2'd0,
    REGION_MMIO  = 2'd1,
    REGION_FAULT = 2'd2
  } region_e;

  // RAM wins over MMIO if the two ever overlap; anything else is a fault.
  function automatic region_e decodeRegion(input logic [31:0] addr,
                                           input logic [31:0] ramBytes,
                                           input logic [27:0] mmioPage);
    if (addr < ramBytes)
      return REGION_RAM;
    else if (addr[31:4] == mmioPage)
      return REGION_MMIO;
    else
      return REGION_FAULT;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// dmem_if: processor data-memory bus.
//   master (core):      drives mem_read, mem_write, address, mem_write_data
//   slave  (responder): drives mem_read_data (combinational, same cycle)
interface dmem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (output mem_read, mem_write, address, mem_write_data,
                  input  mem_read_data);
  modport slave  (input  mem_read, mem_write, address, mem_write_data,
                  output mem_read_data);
endinterface

// File: rtl/data_mem_responder_tx_fifo.sv
// tx_fifo: synchronous byte FIFO feeding the console TX drain.
// Ports:
//   clock, rst      rising-edge clock, async active-low reset
//   i_push          push request (byte from TX_DATA store)
//   i_pushData      byte to push
//   i_popReq        consumer ready; a pop happens only while non-empty
//   o_valid/o_data  head byte (o_data is 0 while empty)
//   o_full/o_empty  occupancy flags
//   o_count         number of stored entries
//   o_overflow      sticky: a push was dropped because the FIFO was full
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_popReq,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             w_full;
  logic             w_empty;
  logic             w_doPop;
  logic             w_doPush;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_doPop = i_popReq & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_doPush = i_push & (~w_full | w_doPop);

  // Storage is not reset; emptiness is tracked by the count alone.
  always_ff @(posedge clock) begin
    if (w_doPush)
      r_mem[r_wptr] <= i_pushData;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_doPush)
        r_wptr <= r_wptr + PW'(1);
      if (w_doPop)
        r_rptr <= r_rptr + PW'(1);
      if (w_doPush && !w_doPop)
        r_count <= r_count + CW'(1);
      else if (w_doPop && !w_doPush)
        r_count <= r_count - CW'(1);
      if (i_push && !w_doPush)
        r_overflow <= 1'b1;
    end
  end

  assign o_valid    = ~w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the core's data-memory interface.
// Serves word-addressed RAM plus a 16-byte MMIO page (TX_DATA, STATUS,
// CYCLE, TOHOST). RAM contents are not reset and start undefined.
// Optional feature macro: DMEM_CYCLE_COUNTER_EN enables the CYCLE counter;
// without it CYCLE reads 0.
// Ports:
//   clock, rst      rising-edge clock, async active-low reset
//   bus             dmem_if.slave (mem_read/mem_write/address/data)
//   tx_valid/data   console FIFO head; tx_ready pops it
//   tohost_valid    sticky, set by a TOHOST store; tohost_data holds value
//   access_fault    sticky, set by any strobe to an unmapped address
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        rst,
  dmem_if.slave       bus,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  output logic        access_fault
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]   r_ram [DEPTH_WORDS];
  logic          r_tohostValid;
  logic [31:0]   r_tohostData;
  logic          r_fault;

  region_e       w_region;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_slot;
  logic          w_strobe;
  logic          w_ramWe;
  logic          w_txPush;
  logic          w_tohostWe;
  logic          w_fifoFull;
  logic          w_fifoEmpty;
  logic [CW-1:0] w_fifoCount;
  logic          w_overflow;
  logic [31:0]   w_status;
  logic [31:0]   w_cycle;
  logic [31:0]   w_rdata;

  assign w_region   = decodeRegion(bus.address, RAM_BYTES, MMIO_BASE[31:4]);
  assign w_idx      = bus.address[AW+1:2];
  assign w_slot     = bus.address[3:2];
  assign w_strobe   = bus.mem_read | bus.mem_write;
  assign w_ramWe    = bus.mem_write && (w_region == REGION_RAM);
  assign w_txPush   = bus.mem_write && (w_region == REGION_MMIO) && (w_slot == OFS_TX_DATA[3:2]);
  assign w_tohostWe = bus.mem_write && (w_region == REGION_MMIO) && (w_slot == OFS_TOHOST[3:2]);

  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_txFifo (
    .clock      (clock),
    .rst        (rst),
    .i_push     (w_txPush),
    .i_pushData (bus.mem_write_data[7:0]),
    .i_popReq   (tx_ready),
    .o_valid    (tx_valid),
    .o_data     (tx_data),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty),
    .o_count    (w_fifoCount),
    .o_overflow (w_overflow)
  );

  // RAM write port; a same-cycle read sees the old word because reads are combinational.
  always_ff @(posedge clock) begin
    if (w_ramWe)
      r_ram[w_idx] <= bus.mem_write_data;
  end

  // Sticky TOHOST and fault flags.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_tohostValid <= 1'b0;
      r_tohostData  <= '0;
      r_fault       <= 1'b0;
    end else begin
      if (w_tohostWe) begin
        r_tohostValid <= 1'b1;
        r_tohostData  <= bus.mem_write_data;
      end
      if (w_strobe && (w_region == REGION_FAULT))
        r_fault <= 1'b1;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;

  // Free-running cycle counter, wraps at 2^32.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)
      r_cycle <= '0;
    else
      r_cycle <= r_cycle + 32'd1;
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  // STATUS word assembly.
  always_comb begin
    w_status = '0;
    w_status[STATUS_COUNT_W-1:0]   = STATUS_COUNT_W'(w_fifoCount);
    w_status[STATUS_EMPTY_BIT]     = w_fifoEmpty;
    w_status[STATUS_FULL_BIT]      = w_fifoFull;
    w_status[STATUS_OVERFLOW_BIT]  = w_overflow;
  end

  // Zero-latency read mux; faults and idle cycles return 0.
  always_comb begin
    w_rdata = '0;
    if (bus.mem_read) begin
      case (w_region)
        REGION_RAM: w_rdata = r_ram[w_idx];
        REGION_MMIO: begin
          case (w_slot)
            OFS_STATUS[3:2]: w_rdata = w_status;
            OFS_CYCLE[3:2]:  w_rdata = w_cycle;
            OFS_TOHOST[3:2]: w_rdata = r_tohostData;
            default:         w_rdata = '0;
          endcase
        end
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.mem_read_data = w_rdata;
  assign tohost_valid      = r_tohostValid;
  assign tohost_data       = r_tohostData;
  assign access_fault      = r_fault;

endmodule
